// File: rtl/generator_pkg.sv
// generator_pkg: shared waveform codes and sample constants for wave_gen
package generator_pkg;
  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_t;
  localparam int SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;
  localparam int SINE_LUT_DEPTH = 64;
endpackage

// File: rtl/sine_lut.sv
// sine_lut: quarter-wave sine magnitude ROM with registered read
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   addr : 6-bit quarter-wave index
//   mag  : 11-bit magnitude, round(2047*sin(pi/2*(addr+0.5)/64)), one cycle after addr
module sine_lut
  import generator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  addr,
  output logic [10:0] mag
);
  localparam logic [10:0] LUT [SINE_LUT_DEPTH] = '{
    11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
    11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
    11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
    11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
    11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
    11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
    11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
    11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
  };
  // Reset value matches the entry for phase 0 so mag always tracks the phase register
  always_ff @(posedge clk or negedge rst)
    if (!rst) mag <= LUT[0];
    else      mag <= LUT[addr];
endmodule

// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator waveform generator feeding the DAC sequencer
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   en         : 1 = generate, 0 = hold phase and output
//   freq_word  : phase increment per sample tick
//   wave_sel   : 0 square, 1 sawtooth, 2 triangle, 3 sine
//   data       : unsigned 12-bit sample
//   sample_stb : one-clk pulse when data updates
module wave_gen
  import generator_pkg::*;
#(
  parameter int DIV     = 100,
  parameter int PHASE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic [1:0]          wave_sel,
  output logic [SAMPLE_W-1:0] data,
  output logic                sample_stb
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0]         cnt;
  logic                  tick;
  logic [PHASE_W:0]      sum;
  logic [PHASE_W-1:0]    phase;
  logic [PHASE_W-1:0]    phase_nxt;
  wave_t                 wave_act;
  logic                  v1;
  logic [5:0]            idx_nxt;
  logic [5:0]            lut_addr;
  logic [10:0]           mag;
  logic                  m;
  logic [SAMPLE_W-1:0]   x;
  logic [SAMPLE_W:0]     sine_sum;
  logic [SAMPLE_W-1:0]   sine_s;
  logic [SAMPLE_W-1:0]   sample;
  assign tick = en && (cnt == CW'(DIV - 1));
  assign sum = {1'b0, phase} + {1'b0, freq_word};
  assign phase_nxt = tick ? sum[PHASE_W-1:0] : phase;
  // The LUT is addressed from the phase about to be registered, so its
  // registered output lines up with the phase register in the mapping stage
  assign idx_nxt = phase_nxt[PHASE_W-3 -: 6];
  assign lut_addr = phase_nxt[PHASE_W-2] ? ~idx_nxt : idx_nxt;
  sine_lut u_lut (
    .clk  (clk),
    .rst  (rst),
    .addr (lut_addr),
    .mag  (mag)
  );
  always_comb begin
    m = phase[PHASE_W-1];
    x = phase[PHASE_W-2 -: SAMPLE_W];
    sine_sum = m ? 13'd2048 - {2'b00, mag} : 13'd2048 + {2'b00, mag};
    sine_s = sine_sum[SAMPLE_W] ? {SAMPLE_W{1'b1}} : sine_sum[SAMPLE_W-1:0];
    sample = wave_act == WAVE_SQUARE ? {SAMPLE_W{m}} :
             wave_act == WAVE_SAW    ? phase[PHASE_W-1 -: SAMPLE_W] :
             wave_act == WAVE_TRI    ? (m ? ~x : x) : sine_s;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt        <= '0;
      phase      <= '0;
      wave_act   <= WAVE_SAW;
      v1         <= 1'b0;
      data       <= MIDSCALE;
      sample_stb <= 1'b0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) phase <= sum[PHASE_W-1:0];
      // Waveform switches only on a phase wrap or while idle, never mid-cycle
      if (!en || (tick && sum[PHASE_W])) wave_act <= wave_t'(wave_sel);
      v1         <= tick;
      sample_stb <= v1;
      if (v1) data <= sample;
    end
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed scoreboard bench for wave_gen
module tb_wave_gen;
  localparam int DIV = 4;
  localparam int PW  = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] freq_word = 16'h1000;
  logic [1:0]  wave_sel = 2'd1;
  logic [11:0] data;
  logic        sample_stb;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  logic [15:0] m_phase = '0;
  logic [1:0]  m_wave = 2'd1;
  logic [11:0] sweep[256];
  wave_gen #(.DIV(DIV), .PHASE_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .freq_word  (freq_word),
    .wave_sel   (wave_sel),
    .data       (data),
    .sample_stb (sample_stb)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] model(input logic [15:0] p, input logic [1:0] w);
    int a;
    int mag;
    case (w)
      2'd0: return p[15] ? 12'd4095 : 12'd0;
      2'd1: return p[15:4];
      2'd2: return p[15] ? ~p[14:3] : p[14:3];
      default: begin
        a = p[14] ? 63 - int'(p[13:8]) : int'(p[13:8]);
        mag = $rtoi(2047.0 * $sin(3.14159265358979 * (a + 0.5) / 128.0) + 0.5);
        return p[15] ? 12'(2048 - mag) : 12'((2048 + mag > 4095) ? 4095 : 2048 + mag);
      end
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_stb(output int cyc, output bit ok, output bit bad);
    logic [11:0] held;
    held = data;
    cyc = 0;
    ok = 1'b0;
    bad = 1'b0;
    while (cyc < 50 && !ok) begin
      @(negedge clk);
      cyc++;
      ok = sample_stb;
      if (!sample_stb && data !== held) bad = 1'b1;
    end
  endtask
  task automatic run_samples(input string tag, input int n, input int first_gap);
    int cyc;
    bit ok;
    bit bad;
    logic [16:0] s;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, m_phase} + {1'b0, freq_word};
      m_phase = s[15:0];
      if (s[16]) m_wave = wave_sel;
      exp_q.push_back(model(m_phase, m_wave));
      wait_stb(cyc, ok, bad);
      chk({tag, " strobe"}, 32'(ok), 32'd1);
      if (!ok) begin
        exp_q.delete();
        return;
      end
      chk({tag, " data"}, 32'(data), 32'(exp_q.pop_front()));
      chk({tag, " hold"}, 32'(bad), 32'd0);
      if (i > 0 || first_gap > 0) chk({tag, " gap"}, 32'(cyc), 32'(i == 0 ? first_gap : DIV));
    end
  endtask
  task automatic frozen(input string tag, input int n, input logic [11:0] val);
    int n_stb;
    bit stuck;
    n_stb = 0;
    stuck = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (sample_stb) n_stb++;
      if (data !== val) stuck = 1'b0;
    end
    chk({tag, " no strobe"}, 32'(n_stb), 32'd0);
    chk({tag, " data held"}, 32'(stuck), 32'd1);
  endtask
  initial begin
    int bad_range;
    cycles(3);
    chk("reset data", 32'(data), 32'h800);
    chk("reset stb", 32'(sample_stb), 32'd0);
    rst = 1'b1;
    frozen("idle", 50, 12'h800);
    m_phase = '0;
    m_wave = 2'd1;
    en = 1'b1;
    run_samples("saw", 17, 5);
    run_samples("saw", 4, DIV);
    wave_sel = 2'd0;
    run_samples("switch", 16, DIV);
    run_samples("square run", 2, DIV);
    cycles(3);
    en = 1'b0;
    run_samples("en drop", 1, 1);
    wave_sel = 2'd1;
    m_wave = 2'd1;
    frozen("en low", 20, 12'hfff);
    en = 1'b1;
    run_samples("resume", 4, 5);
    @(posedge clk);
    #2 rst = 1'b0;
    en = 1'b0;
    #1;
    chk("midrun reset data", 32'(data), 32'h800);
    chk("midrun reset stb", 32'(sample_stb), 32'd0);
    cycles(2);
    rst = 1'b1;
    wave_sel = 2'd0;
    freq_word = 16'h4000;
    cycles(3);
    m_phase = '0;
    m_wave = 2'd0;
    en = 1'b1;
    run_samples("square", 6, 5);
    en = 1'b0;
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    wave_sel = 2'd3;
    cycles(2);
    m_phase = '0;
    m_wave = 2'd3;
    en = 1'b1;
    run_samples("sine", 4, 5);
    en = 1'b0;
    freq_word = 16'h0100;
    cycles(2);
    en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      run_samples("sweep", 1, k == 0 ? 0 : DIV);
      sweep[k] = data;
    end
    bad_range = 0;
    for (int k = 0; k < 256; k++) if (sweep[k] < 12'd1) bad_range++;
    chk("sweep range", 32'(bad_range), 32'd0);
    for (int k = 0; k < 128; k++) chk("sweep symmetry", 32'(sweep[k]) + 32'(sweep[k+128]), 32'd4096);
    en = 1'b0;
    wave_sel = 2'd2;
    freq_word = 16'h2000;
    cycles(2);
    m_wave = 2'd2;
    en = 1'b1;
    run_samples("tri", 8, 0);
    en = 1'b0;
    cycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
